// File: rtl/dp_pkg.sv
// Shared types for the single-bus datapath: opcodes, sequencer states and bus sources.
package dp_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SHR  = 4'd4,
    OP_SHRA = 4'd5,
    OP_SHL  = 4'd6,
    OP_ROR  = 4'd7,
    OP_ROL  = 4'd8,
    OP_MUL  = 4'd9,
    OP_DIV  = 4'd10,
    OP_NEG  = 4'd11,
    OP_NOT  = 4'd12,
    OP_MFHI = 4'd13,
    OP_MFLO = 4'd14,
    OP_IN   = 4'd15
  } dp_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TA,
    S_TB,
    S_TDIV,
    S_TC
  } dp_state_t;

  typedef enum logic [2:0] {
    BS_GPR,
    BS_HI,
    BS_LO,
    BS_ZHI,
    BS_ZLO,
    BS_INPORT
  } dp_bus_src_t;

  // MUL and DIV retire into HI/LO instead of a general register.
  function automatic logic is_hilo_op(input dp_op_t o);
    return (o == OP_MUL) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; the first bit is resolved on load.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_in, quo_in, dvs_in, rem_nxt, quo_nxt;
  logic [WIDTH:0]   trial, diff;
  logic             fits;

  // With divisor 0 every trial fits, so the quotient fills with ones and the
  // remainder ends up holding the dividend without any special casing.
  always_comb begin
    rem_in  = load ? '0 : rem_q;
    quo_in  = load ? dividend : quo_q;
    dvs_in  = load ? divisor : dvs_q;
    trial   = {rem_in, quo_in[WIDTH-1]};
    diff    = trial - {1'b0, dvs_in};
    fits    = trial >= {1'b0, dvs_in};
    rem_nxt = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_nxt = {quo_in[WIDTH-2:0], fits};
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      dz    <= 1'b0;
    end else if (load) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      dvs_q <= divisor;
      cnt_q <= CW'(WIDTH - 1);
      dz    <= (divisor == '0);
    end else if (cnt_q != '0) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign ready     = (cnt_q == '0);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/bus_datapath_seq.sv
// Single-bus datapath with T-state sequencer: Rs->Y, Rt->ALU->Z, Z->Rd or HI/LO.
module bus_datapath_seq
  import dp_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NREGS   = 16,
  parameter int R0_ZERO = 1,
  localparam int RW     = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [RW-1:0]    rd,
  input  logic [RW-1:0]    rs,
  input  logic [RW-1:0]    rt,
  input  logic [WIDTH-1:0] in_port,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] bus,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  input  logic [RW-1:0]    dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  localparam int SW = $clog2(WIDTH);

  dp_state_t   state, state_nxt;
  dp_op_t      op_q;
  logic [RW-1:0] rd_q, rs_q, rt_q;

  logic [NREGS-1:0][WIDTH-1:0] gpr;
  logic [WIDTH-1:0]   y_q, hi_q, lo_q;
  logic [2*WIDTH-1:0] z_q;

  dp_bus_src_t   bsrc;
  logic [RW-1:0] gsel;
  logic          gpr_we;

  logic [2*WIDTH-1:0] alu, a_ext, b_ext, rot_r, rot_l;
  logic [SW-1:0]      sh;

  logic             div_load, div_ready, div_dz;
  logic [WIDTH-1:0] div_quo, div_rem;

  // ---------------- sequencer ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_TA;
      S_TA:   state_nxt = S_TB;
      S_TB:   state_nxt = (op_q == OP_DIV) ? S_TDIV : S_TC;
      S_TDIV: if (div_ready) state_nxt = S_TC;
      S_TC:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- bus mux ----------------
  always_comb begin
    bsrc = BS_ZLO;
    gsel = rs_q;
    case (state)
      S_TA: bsrc = BS_GPR;
      S_TB: begin
        gsel = rt_q;
        case (op_q)
          OP_MFHI: bsrc = BS_HI;
          OP_MFLO: bsrc = BS_LO;
          OP_IN:   bsrc = BS_INPORT;
          default: bsrc = BS_GPR;
        endcase
      end
      default: bsrc = BS_ZLO;
    endcase
  end

  always_comb begin
    case (bsrc)
      BS_GPR:    bus = gpr[gsel];
      BS_HI:     bus = hi_q;
      BS_LO:     bus = lo_q;
      BS_ZHI:    bus = z_q[2*WIDTH-1:WIDTH];
      BS_ZLO:    bus = z_q[WIDTH-1:0];
      BS_INPORT: bus = in_port;
      default:   bus = '0;
    endcase
  end

  // ---------------- ALU: A = Y, B = bus ----------------
  always_comb begin
    a_ext = {{WIDTH{1'b0}}, y_q};
    b_ext = {{WIDTH{1'b0}}, bus};
    sh    = bus[SW-1:0];
    rot_r = {y_q, y_q} >> sh;
    rot_l = {y_q, y_q} << sh;
    alu   = '0;
    case (op_q)
      OP_ADD:  alu[WIDTH-1:0] = y_q + bus;
      OP_SUB:  alu[WIDTH-1:0] = y_q - bus;
      OP_AND:  alu[WIDTH-1:0] = y_q & bus;
      OP_OR:   alu[WIDTH-1:0] = y_q | bus;
      OP_SHR:  alu[WIDTH-1:0] = y_q >> sh;
      OP_SHRA: alu[WIDTH-1:0] = $signed(y_q) >>> sh;
      OP_SHL:  alu[WIDTH-1:0] = y_q << sh;
      OP_ROR:  alu[WIDTH-1:0] = rot_r[WIDTH-1:0];
      OP_ROL:  alu[WIDTH-1:0] = rot_l[2*WIDTH-1:WIDTH];
      OP_MUL:  alu = a_ext * b_ext;
      OP_NEG:  alu[WIDTH-1:0] = '0 - y_q;
      OP_NOT:  alu[WIDTH-1:0] = ~y_q;
      OP_MFHI, OP_MFLO, OP_IN: alu[WIDTH-1:0] = bus;
      default: alu = '0;
    endcase
  end

  // ---------------- divider ----------------
  assign div_load = (state == S_TB) && (op_q == OP_DIV);

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .clr       (clr),
    .load      (div_load),
    .dividend  (y_q),
    .divisor   (bus),
    .ready     (div_ready),
    .quotient  (div_quo),
    .remainder (div_rem),
    .dz        (div_dz)
  );

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= S_IDLE;
      op_q  <= OP_ADD;
      rd_q  <= '0;
      rs_q  <= '0;
      rt_q  <= '0;
      y_q   <= '0;
      z_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start) begin
        op_q <= dp_op_t'(op);
        rd_q <= rd;
        rs_q <= rs;
        rt_q <= rt;
      end
      if (state == S_TA) y_q <= bus;
      if (state == S_TB && op_q != OP_DIV) z_q <= alu;
      if (state == S_TDIV && div_ready) z_q <= {div_rem, div_quo};
      if (state == S_TC && is_hilo_op(op_q)) begin
        hi_q <= z_q[2*WIDTH-1:WIDTH];
        lo_q <= z_q[WIDTH-1:0];
      end
    end
  end

  // R0 is never written when hard-wired, so it stays at its cleared value of 0.
  assign gpr_we = (state == S_TC) && !is_hilo_op(op_q) &&
                  !((R0_ZERO != 0) && (rd_q == '0));

  always_ff @(posedge clk) begin
    if (clr)         gpr <= '0;
    else if (gpr_we) gpr[rd_q] <= bus;
  end

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_TC);
  assign div0     = done && (op_q == OP_DIV) && div_dz;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign dbg_data = gpr[dbg_sel];

endmodule

// File: tb/tb_bus_datapath_seq.sv
// Bench for bus_datapath_seq: directed table, hazard/reset sequences, random ops vs a reference model.
module tb_bus_datapath_seq;
  import dp_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr, start_a, start_b;
  logic [3:0]  op, rd, rs, rt, dbg_sel;
  logic [31:0] in_port;

  logic        busy_a, done_a, div0_a;
  logic [31:0] bus_a, hi_a, lo_a, dbg_a;
  logic        busy_b, done_b, div0_b;
  logic [15:0] bus_b, hi_b, lo_b, dbg_b;

  bus_datapath_seq #(.WIDTH(32), .NREGS(16), .R0_ZERO(1)) dut_a (
    .clk(clk), .clr(clr), .start(start_a), .op(op), .rd(rd), .rs(rs), .rt(rt),
    .in_port(in_port), .busy(busy_a), .done(done_a), .div0(div0_a), .bus(bus_a),
    .hi(hi_a), .lo(lo_a), .dbg_sel(dbg_sel), .dbg_data(dbg_a));

  bus_datapath_seq #(.WIDTH(16), .NREGS(8), .R0_ZERO(1)) dut_b (
    .clk(clk), .clr(clr), .start(start_b), .op(op), .rd(rd[2:0]), .rs(rs[2:0]), .rt(rt[2:0]),
    .in_port(in_port[15:0]), .busy(busy_b), .done(done_b), .div0(div0_b), .bus(bus_b),
    .hi(hi_b), .lo(lo_b), .dbg_sel(dbg_sel[2:0]), .dbg_data(dbg_b));

  int checks = 0;
  int errors = 0;

  // reference model of the 32-bit instance
  logic [31:0] m_reg [16];
  logic [31:0] m_hi, m_lo;
  bit          m_dz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_reg[i] = '0;
    m_hi = '0;
    m_lo = '0;
  endtask

  task automatic model_exec(input logic [3:0] o, input logic [3:0] d, input logic [3:0] s,
                            input logic [3:0] t, input logic [31:0] v);
    logic [31:0] a, b, r;
    logic [63:0] p;
    int n;
    a = m_reg[s];
    b = m_reg[t];
    n = int'(b % 32);
    r = '0;
    m_dz = 0;
    case (o)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a >> n;
      4'd5:  begin r = a >> n; if (a[31]) r = r | ~(32'hFFFF_FFFF >> n); end
      4'd6:  r = a << n;
      4'd7:  begin r = a; repeat (n) r = {r[0], r[31:1]}; end
      4'd8:  begin r = a; repeat (n) r = {r[30:0], r[31]}; end
      4'd9:  begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      4'd10: begin
        if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; m_dz = 1; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
      4'd11: r = 32'd0 - a;
      4'd12: r = ~a;
      4'd13: r = m_hi;
      4'd14: r = m_lo;
      default: r = v;
    endcase
    if (o != 4'd9 && o != 4'd10 && d != 0) m_reg[d] = r;
  endtask

  // Issue one op on instance a (inst=0) or b (inst=1); returns done latency from the start cycle.
  task automatic run_op(input bit inst, input logic [3:0] o, input logic [3:0] d,
                        input logic [3:0] s, input logic [3:0] t, input logic [31:0] v,
                        output int lat, output bit dz);
    if (!inst) model_exec(o, d, s, t, v);
    @(negedge clk);
    op = o; rd = d; rs = s; rt = t; in_port = v;
    if (inst) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    chk("busy_cycle1", 32'(inst ? busy_b : busy_a), 32'd1);
    op = 4'($urandom); rd = 4'($urandom); rs = 4'($urandom); rt = 4'($urandom);
    lat = -1;
    dz  = 0;
    for (int c = 1; c < 100; c++) begin
      if (inst ? done_b : done_a) begin
        lat = c;
        dz  = inst ? div0_b : div0_a;
        break;
      end
      @(negedge clk);
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done within 100 cycles, expected a pulse");
    end
    @(negedge clk);
    chk("busy_after_done", 32'(inst ? busy_b : busy_a), 32'd0);
  endtask

  task automatic peek_a(input logic [3:0] r, output logic [31:0] val);
    dbg_sel = r; #1; val = dbg_a;
  endtask

  task automatic peek_b(input logic [3:0] r, output logic [31:0] val);
    dbg_sel = r; #1; val = 32'(dbg_b);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, lo, hi;
    bit          hilo;
    int          lat;
    bit          dz;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int lat;
    bit dz;
    bit seen;
    logic [31:0] v, exp_v;
    logic [3:0] ro, rdd, rss, rtt;

    tbl[0]  = '{OP_ADD,  32'd5,          32'd7,          32'd12,         32'd0, 0, 3, 0};
    tbl[1]  = '{OP_SUB,  32'd0,          32'd1,          32'hFFFF_FFFF,  32'd0, 0, 3, 0};
    tbl[2]  = '{OP_SHRA, 32'h8000_0000,  32'd4,          32'hF800_0000,  32'd0, 0, 3, 0};
    tbl[3]  = '{OP_ROL,  32'h8000_0001,  32'd1,          32'h0000_0003,  32'd0, 0, 3, 0};
    tbl[4]  = '{OP_MUL,  32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  32'd1, 1, 3, 0};
    tbl[5]  = '{OP_DIV,  32'd100,        32'd7,          32'd14,         32'd2, 1, 35, 0};
    tbl[6]  = '{OP_DIV,  32'd1234,       32'd0,          32'hFFFF_FFFF,  32'd1234, 1, 35, 1};
    tbl[7]  = '{OP_AND,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  32'd0, 0, 3, 0};
    tbl[8]  = '{OP_OR,   32'h1234_0000,  32'h0000_5678,  32'h1234_5678,  32'd0, 0, 3, 0};
    tbl[9]  = '{OP_SHR,  32'h8000_0000,  32'h0000_0024,  32'h0800_0000,  32'd0, 0, 3, 0};
    tbl[10] = '{OP_SHL,  32'd1,          32'd31,         32'h8000_0000,  32'd0, 0, 3, 0};
    tbl[11] = '{OP_ROR,  32'd1,          32'd1,          32'h8000_0000,  32'd0, 0, 3, 0};
    tbl[12] = '{OP_NEG,  32'd1,          32'd9,          32'hFFFF_FFFF,  32'd0, 0, 3, 0};
    tbl[13] = '{OP_NOT,  32'h0F0F_0F0F,  32'd9,          32'hF0F0_F0F0,  32'd0, 0, 3, 0};

    clr = 1'b1; start_a = 1'b0; start_b = 1'b0;
    op = '0; rd = '0; rs = '0; rt = '0; in_port = '0; dbg_sel = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy_a), 32'd0);
    chk("reset_done", 32'(done_a), 32'd0);
    chk("reset_hi", hi_a, 32'd0);
    chk("reset_lo", lo_a, 32'd0);
    peek_a(4'd5, v); chk("reset_r5", v, 32'd0);
    clr = 1'b0;

    // directed table: R1 = a, R2 = b via IN, then op r3,r1,r2
    for (int i = 0; i < 14; i++) begin
      run_op(0, OP_IN, 4'd1, 4'd0, 4'd0, tbl[i].a, lat, dz);
      run_op(0, OP_IN, 4'd2, 4'd0, 4'd0, tbl[i].b, lat, dz);
      run_op(0, tbl[i].op, 4'd3, 4'd1, 4'd2, 32'd0, lat, dz);
      chk($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_div0", i), 32'(dz), 32'(tbl[i].dz));
      if (tbl[i].hilo) begin
        chk($sformatf("tbl%0d_hi", i), hi_a, tbl[i].hi);
        chk($sformatf("tbl%0d_lo", i), lo_a, tbl[i].lo);
      end else begin
        peek_a(4'd3, v); chk($sformatf("tbl%0d_r3", i), v, tbl[i].lo);
      end
    end

    // MFHI/MFLO after DIV 100/7
    run_op(0, OP_IN, 4'd1, 4'd0, 4'd0, 32'd100, lat, dz);
    run_op(0, OP_IN, 4'd2, 4'd0, 4'd0, 32'd7, lat, dz);
    run_op(0, OP_DIV, 4'd9, 4'd1, 4'd2, 32'd0, lat, dz);
    run_op(0, OP_MFHI, 4'd4, 4'd0, 4'd0, 32'd0, lat, dz);
    run_op(0, OP_MFLO, 4'd5, 4'd0, 4'd0, 32'd0, lat, dz);
    peek_a(4'd4, v); chk("mfhi_r4", v, 32'd2);
    peek_a(4'd5, v); chk("mflo_r5", v, 32'd14);

    // same register as source and destination
    run_op(0, OP_IN, 4'd1, 4'd0, 4'd0, 32'd3, lat, dz);
    run_op(0, OP_ADD, 4'd1, 4'd1, 4'd1, 32'd0, lat, dz);
    peek_a(4'd1, v); chk("add_r1_self", v, 32'd6);

    // write to R0 completes but is dropped
    run_op(0, OP_IN, 4'd0, 4'd0, 4'd0, 32'hDEAD_BEEF, lat, dz);
    chk("r0_write_latency", lat, 32'd3);
    peek_a(4'd0, v); chk("r0_stays_zero", v, 32'd0);

    // start while busy is ignored
    run_op(0, OP_IN, 4'd6, 4'd0, 4'd0, 32'h66, lat, dz);
    model_exec(OP_ADD, 4'd5, 4'd1, 4'd1, 32'd0);
    @(negedge clk); op = OP_ADD; rd = 4'd5; rs = 4'd1; rt = 4'd1; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    @(negedge clk); start_a = 1'b1; op = OP_IN; rd = 4'd6; in_port = 32'h99;
    @(negedge clk); chk("ignored_start_done_c3", 32'(done_a), 32'd1); start_a = 1'b0;
    @(negedge clk); chk("ignored_start_busy_c4", 32'(busy_a), 32'd0);
    @(negedge clk); chk("ignored_start_busy_c5", 32'(busy_a), 32'd0);
    peek_a(4'd6, v); chk("ignored_start_r6", v, 32'h66);
    peek_a(4'd5, v); chk("ignored_start_r5", v, 32'd12);

    // clr in the middle of a DIV
    run_op(0, OP_IN, 4'd1, 4'd0, 4'd0, 32'd50, lat, dz);
    run_op(0, OP_IN, 4'd2, 4'd0, 4'd0, 32'd5, lat, dz);
    @(negedge clk); op = OP_DIV; rd = 4'd0; rs = 4'd1; rt = 4'd2; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    seen = 0;
    repeat (9) begin @(negedge clk); if (done_a) seen = 1; end
    clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    model_reset();
    chk("clr_mid_div_busy", 32'(busy_a), 32'd0);
    chk("clr_mid_div_hi", hi_a, 32'd0);
    chk("clr_mid_div_lo", lo_a, 32'd0);
    peek_a(4'd1, v); chk("clr_mid_div_r1", v, 32'd0);
    repeat (40) begin @(negedge clk); if (done_a) seen = 1; end
    chk("clr_mid_div_no_done", 32'(seen), 32'd0);
    run_op(0, OP_IN, 4'd1, 4'd0, 4'd0, 32'd4, lat, dz);
    run_op(0, OP_IN, 4'd2, 4'd0, 4'd0, 32'd9, lat, dz);
    run_op(0, OP_ADD, 4'd3, 4'd1, 4'd2, 32'd0, lat, dz);
    chk("after_clr_latency", lat, 32'd3);
    peek_a(4'd3, v); chk("after_clr_r3", v, 32'd13);

    // clr and start together: clr wins
    @(negedge clk); clr = 1'b1; start_a = 1'b1; op = OP_IN; rd = 4'd7; in_port = 32'h77;
    @(negedge clk); clr = 1'b0; start_a = 1'b0;
    model_reset();
    chk("clr_start_busy", 32'(busy_a), 32'd0);
    repeat (4) @(negedge clk);
    peek_a(4'd7, v); chk("clr_start_r7", v, 32'd0);

    // 16-bit, 8-register instance
    run_op(1, OP_IN, 4'd1, 4'd0, 4'd0, 32'hFFFF, lat, dz);
    run_op(1, OP_IN, 4'd2, 4'd0, 4'd0, 32'd1, lat, dz);
    run_op(1, OP_ADD, 4'd3, 4'd1, 4'd2, 32'd0, lat, dz);
    chk("w16_add_latency", lat, 32'd3);
    peek_b(4'd3, v); chk("w16_add_wrap", v, 32'd0);
    run_op(1, OP_IN, 4'd4, 4'd0, 4'd0, 32'd1000, lat, dz);
    run_op(1, OP_IN, 4'd5, 4'd0, 4'd0, 32'd7, lat, dz);
    run_op(1, OP_DIV, 4'd0, 4'd4, 4'd5, 32'd0, lat, dz);
    chk("w16_div_latency", lat, 32'd19);
    chk("w16_div_lo", 32'(lo_b), 32'd142);
    chk("w16_div_hi", 32'(hi_b), 32'd6);

    // randomized ops against the reference model
    for (int i = 0; i < 80; i++) begin
      ro  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      rdd = 4'($urandom_range(0, 15));
      rss = 4'($urandom_range(0, 15));
      rtt = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      v   = $urandom;
      run_op(0, ro, rdd, rss, rtt, v, lat, dz);
      chk($sformatf("rnd%0d_op%0d_latency", i, ro), lat, (ro == 4'd10) ? 32'd35 : 32'd3);
      chk($sformatf("rnd%0d_op%0d_div0", i, ro), 32'(dz), 32'(m_dz));
      chk($sformatf("rnd%0d_op%0d_hi", i, ro), hi_a, m_hi);
      chk($sformatf("rnd%0d_op%0d_lo", i, ro), lo_a, m_lo);
      exp_v = m_reg[rdd];
      peek_a(rdd, v);
      chk($sformatf("rnd%0d_op%0d_r%0d", i, ro, rdd), v, exp_v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_datapath_seq.md
# bus_datapath_seq

Parametrised single-bus datapath with its own T-state sequencer: executes one register-register operation per `start` request over the shared bus (Rs→Y, Rt→ALU→Z, Z→Rd/HI/LO), including an iterative divider. It sits between the future control unit and memory interface. It replaces hand-driven enable and bus-select vectors with a `start`/`busy`/`done` handshake and configurable width and register count.

## Interface
Parameters:
- `WIDTH`, 32, datapath width; power of two, at least 8.
- `NREGS`, 16, general registers; power of two; `RW = log2(NREGS)`.
- `R0_ZERO`, 1, when 1: R0 reads as 0 and writes to it are dropped.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `clr`  in  1  reset; synchronous and active-high.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  4  opcode (see Operation).
- `rd`, `rs`, `rt`  in  RW each  destination and source register indices.
- `in_port`  in  WIDTH  external input value for op IN.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse in T_C.
- `div0`  out  1  pulses with `done` when DIV has divisor 0.
- `bus`  out  WIDTH  current bus value (debug).
- `hi`, `lo`  out  WIDTH  HI/LO register contents.
- `dbg_sel`  in  RW  register debug read select.
- `dbg_data`  out  WIDTH  contents of register `dbg_sel`; combinational; honours R0_ZERO.

## Operation
- On accepted `start`, latch `op`/`rd`/`rs`/`rt`. Later changes to these inputs have no effect until the next IDLE.
- FSM states: IDLE → T_A → T_B → [T_DIV] → T_C → IDLE.
  - T_A: bus = Rs; Y ← bus.
  - T_B: bus = Rt; Z ← ALU(Y, bus). For DIV, load `seq_divider` instead.
  - T_DIV (DIV only): stay until divider `ready`.
  - T_C: bus = Zlo; write Rd ← Zlo, or for MUL/DIV: HI ← Zhi, LO ← Zlo; `done` = 1.
- Opcodes, with A = Y and B = Rt:
  - 0 ADD: A+B. 1 SUB: A−B. Both modulo 2^WIDTH.
  - 2 AND, 3 OR.
  - 4 SHR (logical), 5 SHRA (arithmetic), 6 SHL, 7 ROR, 8 ROL. Shift amount = B[log2(WIDTH)−1:0].
  - 9 MUL: unsigned 2·WIDTH-bit product; Zhi:Zlo = A·B.
  - 10 DIV: unsigned; LO = quotient, HI = remainder. Divisor 0 gives LO = all-ones, HI = A, `div0` = 1.
  - 11 NEG: −A. 12 NOT: ~A.
  - 13 MFHI: Rd ← HI. 14 MFLO: Rd ← LO.
  - 15 IN: Rd ← `in_port`, sampled in T_B.
- rs = rt = rd is legal; Y holds the old Rs value.
- `start` while busy is ignored. There is no queue.
- With R0_ZERO = 1, rd = 0 completes normally (`done` pulses) and no register changes.

## Timing
- `clr` (any state): next cycle state = IDLE, all GPRs/HI/LO/Y/Z = 0, divider reset, `busy`/`done`/`div0` = 0. An in-flight op is abandoned with no write and no `done`.
- Cycle numbering: `start` = 1 in IDLE at cycle 0.
  - Non-DIV ops: T_A at cycle 1, T_B at cycle 2, T_C at cycle 3. `busy` is high in cycles 1–3, `done` in cycle 3. The destination is visible from cycle 4, when the next `start` can also be accepted.
- DIV: T_DIV lasts exactly WIDTH cycles. T_C falls at cycle 3+WIDTH and `done` at the same cycle.
- `clr` and `start` asserted together: `clr` wins.

## Structure
- Shared package `dp_pkg` holds:
  - the opcode enum `dp_op_t` (4 bits, values above);
  - the FSM state enum;
  - the bus-source enum (GPR, HI, LO, ZHI, ZLO, INPORT).
- Sub-module `seq_divider`: restoring unsigned divider, parameter WIDTH.
  - Ports: `clk`, `clr`, `load`, `dividend`, `divisor`, `ready`, `quotient`, `remainder`, `dz`.
  - `ready` asserts WIDTH cycles after `load`.
- Top level holds the FSM, register array, Y, Z, HI/LO, the combinational ALU and the bus mux.

## Test plan
- Reset/basic: `clr` then R1 = 5, R2 = 7 (via IN), ADD r3,r1,r2 → `done` at cycle 3, R3 = 12, `busy` low at cycle 4.
- Arithmetic edges: WIDTH = 32. SUB of 0 − 1 → 0xFFFFFFFF. SHRA of 0x80000000 by 4 → 0xF8000000. ROL of 0x80000001 by 1 → 0x00000003.
- MUL/DIV:
  - MUL 0xFFFFFFFF × 2 → HI = 1, LO = 0xFFFFFFFE.
  - DIV 100 / 7 → LO = 14, HI = 2, `done` at cycle 35.
  - DIV by 0 → LO = 0xFFFFFFFF, HI = dividend, `div0` pulses.
- Hazards: `start` during busy is ignored. ADD r1,r1,r1 with R1 = 3 → R1 = 6. R0_ZERO = 1 with write to R0 → `dbg_data`(0) stays 0.
- Reset mid-op: `clr` during T_DIV → no `done`, HI/LO = 0, next op runs normally.
- Parametrisation: WIDTH = 16, NREGS = 8 → ADD 0xFFFF + 1 = 0; DIV `done` at cycle 19.
